// File: rtl/vga_tile_buffer.sv
// Tile memory shared by the bus writer and the VGA fetch path: 600 x 28-bit words,
// four 7-bit fields per word, per-field write strobes, one-cycle registered read.
module vga_tile_buffer #(
    parameter int DEPTH = 600,
    parameter int AW    = 10,
    parameter int DW    = 28,
    parameter int FW    = 7
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] w_addr_i,
    input  logic [3:0]    w_strb_i,
    input  logic [AW-1:0] r_addr_i,
    input  logic          r_req_i,
    input  logic [AW-1:0] vr_addr_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    // Array has no reset; it relies on the zero image loaded at configuration.
    logic [DW-1:0] mem_q [DEPTH];

    logic          wr_hit_s;
    logic [DW-1:0] wr_word_s;
    logic [AW-1:0] raddr_s;
    logic [DW-1:0] dout_d;
    logic [DW-1:0] dout_q;

    function automatic logic [DW-1:0] merge_fields(
        input logic [DW-1:0] old_w,
        input logic [DW-1:0] new_w,
        input logic [3:0]    strb
    );
        logic [DW-1:0] res;
        res = old_w;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[k*FW +: FW] = new_w[k*FW +: FW];
            end else begin
                res[k*FW +: FW] = old_w[k*FW +: FW];
            end
        end
        return res;
    endfunction

    // Write-side merge and read-port address select / range check.
    always_comb begin
        wr_hit_s  = wr_en_i && (w_addr_i < DEPTH_A);
        wr_word_s = '0;
        if (wr_hit_s) begin
            wr_word_s = merge_fields(mem_q[w_addr_i], din_i, w_strb_i);
        end else begin
            wr_word_s = '0;
        end
        raddr_s = r_req_i ? r_addr_i : vr_addr_i;
        dout_d  = '0;
        if (raddr_s < DEPTH_A) begin
            dout_d = mem_q[raddr_s];
        end else begin
            dout_d = '0;
        end
    end

    // Array write; deliberately outside the reset domain so writes proceed during reset.
    always_ff @(posedge clk_i) begin
        if (wr_hit_s) begin
            mem_q[w_addr_i] <= wr_word_s;
        end
    end

    // Read register; sampling the pre-write array gives read-first collisions.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: tb/tb_vga_tile_buffer.sv
// Self-checking bench for vga_tile_buffer: reference array model plus a queue of
// expected read words compared one cycle after each address is presented.
module tb_vga_tile_buffer;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        wr_en_i;
    logic [9:0]  w_addr_i;
    logic [3:0]  w_strb_i;
    logic [9:0]  r_addr_i;
    logic        r_req_i;
    logic [9:0]  vr_addr_i;
    logic [27:0] din_i;
    logic [27:0] dout_o;

    logic [27:0] model [600];
    logic [27:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    vga_tile_buffer dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .wr_en_i  (wr_en_i),
        .w_addr_i (w_addr_i),
        .w_strb_i (w_strb_i),
        .r_addr_i (r_addr_i),
        .r_req_i  (r_req_i),
        .vr_addr_i(vr_addr_i),
        .din_i    (din_i),
        .dout_o   (dout_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one cycle, push the expected read word (pre-write contents), update the model.
    task automatic drive(input logic we, input logic [9:0] wa, input logic [3:0] st,
                         input logic [27:0] d, input logic rq, input logic [9:0] ra,
                         input logic [9:0] va);
        logic [9:0]  rsel;
        logic [27:0] e;
        wr_en_i = we; w_addr_i = wa; w_strb_i = st; din_i = d;
        r_req_i = rq; r_addr_i = ra; vr_addr_i = va;
        rsel = rq ? ra : va;
        e = (rsel < 10'd600) ? model[rsel] : 28'd0;
        exp_q.push_back(e);
        if (we && wa < 10'd600) begin
            for (int k = 0; k < 4; k++) begin
                if (st[k]) model[wa][k*7 +: 7] = d[k*7 +: 7];
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        #1;
        checks++;
        if (dout_o !== 28'd0) begin
            errors++; $display("FAIL reset_initial got=%h exp=%h", dout_o, 28'd0);
        end
        @(posedge clk_i); @(posedge clk_i); #1;
        checks++;
        if (dout_o !== 28'd0) begin
            errors++; $display("FAIL reset_held got=%h exp=%h", dout_o, 28'd0);
        end
        #2 rstn_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_powerup_sweep();
        logic [27:0] e;
        for (int k = 0; k < 600; k++) begin
            drive(1'b1, 10'(k), 4'b0011, 28'(k), 1'b0, 10'd0, 10'(k));
            e = exp_q.pop_front();
            checks++;
            if (dout_o !== e || dout_o !== 28'd0) begin
                errors++; $display("FAIL powerup_read addr=%0d got=%h exp=%h", k, dout_o, e);
            end
        end
    endtask

    task automatic test_full_readback();
        logic [27:0] e;
        for (int k = 0; k < 600; k++) begin
            drive(1'b1, 10'(k), 4'b0011, 28'(k), 1'b0, 10'd0, 10'd0);
            void'(exp_q.pop_front());
        end
        for (int k = 0; k < 600; k++) begin
            drive(1'b0, 10'd0, 4'b0000, 28'd0, 1'b0, 10'd0, 10'(k));
            e = exp_q.pop_front();
            checks++;
            if (dout_o !== e || dout_o !== 28'(k)) begin
                errors++; $display("FAIL readback addr=%0d got=%h exp=%h", k, dout_o, 28'(k));
            end
        end
    endtask

    task automatic test_strobes();
        logic [27:0] e;
        drive(1'b1, 10'd4, 4'b1111, 28'hBBBBBBB, 1'b0, 10'd0, 10'd0);
        void'(exp_q.pop_front());
        drive(1'b0, 10'd0, 4'b0000, 28'd0, 1'b0, 10'd0, 10'd4);
        e = exp_q.pop_front();
        checks++;
        if (dout_o !== e || dout_o !== 28'hBBBBBBB) begin
            errors++; $display("FAIL full_strobe got=%h exp=%h", dout_o, 28'hBBBBBBB);
        end
        drive(1'b1, 10'd4, 4'b0000, 28'h4444444, 1'b0, 10'd0, 10'd0);
        void'(exp_q.pop_front());
        drive(1'b0, 10'd0, 4'b0000, 28'd0, 1'b0, 10'd0, 10'd4);
        e = exp_q.pop_front();
        checks++;
        if (dout_o !== e || dout_o !== 28'hBBBBBBB) begin
            errors++; $display("FAIL zero_strobe got=%h exp=%h", dout_o, 28'hBBBBBBB);
        end
        drive(1'b1, 10'd4, 4'b1010, 28'b0001111000010000010000000011, 1'b0, 10'd0, 10'd0);
        void'(exp_q.pop_front());
        drive(1'b0, 10'd0, 4'b0000, 28'd0, 1'b0, 10'd0, 10'd4);
        e = exp_q.pop_front();
        checks++;
        if (dout_o !== e || dout_o !== 28'b0001111110111000010000111011) begin
            errors++; $display("FAIL partial_strobe got=%b exp=%b", dout_o,
                               28'b0001111110111000010000111011);
        end
    endtask

    task automatic test_reset_midsweep();
        logic [27:0] e;
        for (int k = 0; k < 300; k++) begin
            drive(1'b0, 10'd0, 4'b0000, 28'd0, 1'b0, 10'd0, 10'(k));
            e = exp_q.pop_front();
            checks++;
            if (dout_o !== e) begin
                errors++; $display("FAIL presweep addr=%0d got=%h exp=%h", k, dout_o, e);
            end
        end
        #2 rstn_i = 1'b0;
        #1;
        checks++;
        if (dout_o !== 28'd0) begin
            errors++; $display("FAIL async_reset got=%h exp=%h", dout_o, 28'd0);
        end
        // Write issued while reset is low must still land in the array.
        drive(1'b1, 10'd5, 4'b1111, 28'h1234567, 1'b0, 10'd0, 10'd10);
        void'(exp_q.pop_front());
        checks++;
        if (dout_o !== 28'd0) begin
            errors++; $display("FAIL reset_hold_write got=%h exp=%h", dout_o, 28'd0);
        end
        #2 rstn_i = 1'b1;
        @(posedge clk_i); #1;
        drive(1'b0, 10'd0, 4'b0000, 28'd0, 1'b0, 10'd0, 10'd5);
        e = exp_q.pop_front();
        checks++;
        if (dout_o !== e || dout_o !== 28'h1234567) begin
            errors++; $display("FAIL write_in_reset got=%h exp=%h", dout_o, 28'h1234567);
        end
        for (int k = 0; k < 600; k++) begin
            drive(1'b0, 10'd0, 4'b0000, 28'd0, 1'b0, 10'd0, 10'(k));
            e = exp_q.pop_front();
            checks++;
            if (dout_o !== e) begin
                errors++; $display("FAIL post_reset addr=%0d got=%h exp=%h", k, dout_o, e);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [27:0] e;
        drive(1'b1, 10'd600, 4'b1111, 28'hFFFFFFF, 1'b0, 10'd0, 10'd0);
        void'(exp_q.pop_front());
        drive(1'b1, 10'd1023, 4'b1111, 28'hEEEEEEE, 1'b1, 10'd700, 10'd3);
        e = exp_q.pop_front();
        checks++;
        if (dout_o !== e || dout_o !== 28'd0) begin
            errors++; $display("FAIL oor_read_700 got=%h exp=%h", dout_o, 28'd0);
        end
        drive(1'b0, 10'd0, 4'b0000, 28'd0, 1'b1, 10'd600, 10'd3);
        e = exp_q.pop_front();
        checks++;
        if (dout_o !== e || dout_o !== 28'd0) begin
            errors++; $display("FAIL oor_read_600 got=%h exp=%h", dout_o, 28'd0);
        end
        // Full sweep through the bus read port catches any aliased out-of-range write.
        for (int k = 0; k < 600; k++) begin
            drive(1'b0, 10'd0, 4'b0000, 28'd0, 1'b1, 10'(k), 10'(599 - k));
            e = exp_q.pop_front();
            checks++;
            if (dout_o !== e) begin
                errors++; $display("FAIL oor_noalias addr=%0d got=%h exp=%h", k, dout_o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [27:0] e;
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 10'($urandom_range(0, 639)), 4'($urandom_range(0, 15)),
                  28'($urandom), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 649)),
                  10'($urandom_range(0, 649)));
            e = exp_q.pop_front();
            checks++;
            if (dout_o !== e) begin
                errors++; $display("FAIL back_to_back cycle=%0d got=%h exp=%h", n, dout_o, e);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 600; k++) model[k] = 28'd0;
        wr_en_i = 1'b0; w_addr_i = 10'd0; w_strb_i = 4'b0000; din_i = 28'd0;
        r_req_i = 1'b0; r_addr_i = 10'd0; vr_addr_i = 10'd0;
        test_reset();
        test_powerup_sweep();
        test_full_readback();
        test_strobes();
        test_reset_midsweep();
        test_out_of_range();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
